// File: rtl/sg_result_collector.sv
// Savitzky-Golay result collector: buffers one frame of filtered centre samples, pads both
// edges with the nearest valid sample and streams the full frame out. Optional SG_COLLECT_CHECKSUM_EN.
module sg_result_collector #(
  parameter int unsigned WINDOW_SIZE = 7,
  parameter int unsigned DATA_SIZE   = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
`ifdef SG_COLLECT_CHECKSUM_EN
  ,
  output logic [DATA_W+7:0] checksum
`endif
);

  localparam int unsigned HALF  = WINDOW_SIZE / 2;
  localparam int unsigned N_IN  = DATA_SIZE - 2 * HALF;
  localparam int unsigned IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Reject parameter sets that cannot form a padded frame.
  if ((WINDOW_SIZE % 2) == 0) begin : g_bad_window
    $error("sg_result_collector: WINDOW_SIZE must be odd");
  end
  if (DATA_SIZE <= 2 * HALF) begin : g_bad_size
    $error("sg_result_collector: DATA_SIZE must exceed 2*HALF");
  end
  if ((2 ** ADDR_W) < DATA_SIZE) begin : g_bad_addr
    $error("sg_result_collector: ADDR_W too small for DATA_SIZE");
  end

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] out_idx;
  logic [ADDR_W-1:0] load_idx;
  logic [DATA_W-1:0] mem [DATA_SIZE];
  logic [DATA_W-1:0] head_val;
  logic [DATA_W-1:0] tail_val;
  logic [DATA_W-1:0] beat_val;
  logic              in_fire;
  logic              out_fire;
  logic              last_in;
  logic              last_out;
  logic              load_beat;
  logic              start_ok;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = in_fire && (wr_idx == ADDR_W'(N_IN - 1));
  assign last_out = out_fire && out_last;
  assign wr_addr  = ADDR_W'(HALF) + wr_idx;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next output beat: first beat when nothing is presented, else the successor on handshake.
  always_comb begin
    load_beat = 1'b0;
    load_idx  = '0;
    beat_val  = '0;
    if (state_q == S_DRAIN) begin
      load_beat = !out_valid || (out_ready && !out_last);
    end
    if (out_valid) begin
      load_idx = out_idx + ADDR_W'(1);
    end
    if (load_idx < ADDR_W'(HALF)) begin
      beat_val = head_val;
    end else if (load_idx >= ADDR_W'(DATA_SIZE - HALF)) begin
      beat_val = tail_val;
    end else begin
      beat_val = mem[IDX_W'(load_idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (last_in) state_d = S_DRAIN;
      S_DRAIN:   if (last_out) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_COLLECT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Frame buffer has no reset; every centre slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[IDX_W'(wr_addr)] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      wr_idx    <= '0;
      out_idx   <= '0;
      head_val  <= '0;
      tail_val  <= '0;
    end else begin
      if (start_ok) begin
        in_ready <= 1'b1;
        done     <= 1'b0;
        wr_idx   <= '0;
        out_idx  <= '0;
      end
      if (state_q == S_COLLECT && in_fire) begin
        if (wr_idx == '0) head_val <= in_data;
        if (last_in) begin
          tail_val <= in_data;
          in_ready <= 1'b0;
        end
        if (wr_idx != ADDR_W'(N_IN)) wr_idx <= wr_idx + ADDR_W'(1);
      end
      if (load_beat) begin
        out_valid <= 1'b1;
        out_idx   <= load_idx;
        out_data  <= beat_val;
        out_last  <= (load_idx == ADDR_W'(DATA_SIZE - 1));
      end else if (state_q == S_DRAIN && last_out) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

`ifdef SG_COLLECT_CHECKSUM_EN
  // Running sum of every drained beat, sign-extended to the wider accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (out_fire) begin
      checksum <= checksum + (DATA_W + 8)'($signed(out_data));
    end
  end
`else
  // No accumulator in this build.
`endif

endmodule

// File: tb/tb_sg_result_collector.sv
// Directed bench for sg_result_collector (WINDOW_SIZE=7, DATA_SIZE=30): padding, stalls,
// ignored start, mid-frame reset, back-to-back frames and optional checksum.
module tb_sg_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
`ifdef SG_COLLECT_CHECKSUM_EN
  logic [39:0] checksum;
`endif

  int checks = 0;
  int passes = 0;

  sg_result_collector #(
    .WINDOW_SIZE(7), .DATA_SIZE(30), .DATA_W(32), .ADDR_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
`ifdef SG_COLLECT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed 24 centre samples base+step*k; optionally pulse start or abort with rst after some beats.
  task automatic collect(input int base, input int step, input bit gaps,
                         input int start_at, input int abort_at);
    int k = 0;
    int cyc = 0;
    bit started = 1'b0;
    while (k < 24 && cyc < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = base + step * k;
      start    = (k == start_at) && !started;
      if (start) started = 1'b1;
      if (in_valid && in_ready) k++;
      tick();
      cyc++;
      start = 1'b0;
      if (k == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("collect_beats", k, 24);
    chk("in_ready_drain", in_ready, 0);
  endtask

  // Drain 30 beats and check padding model: value = base + step*clamp(i-3, 0, 23).
  task automatic drain(input int base, input int step, input bit toggle);
    int i = 0;
    int cyc = 0;
    int j;
    while (i < 30 && cyc < 600) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid  = 1'b1;
      if (out_valid) begin
        j = (i < 3) ? 0 : ((i > 26) ? 23 : i - 3);
        chk("out_data", longint'($signed(out_data)), base + step * j);
        chk("out_last", out_last, (i == 29) ? 1 : 0);
        chk("in_ready_drain", in_ready, 0);
        if (out_ready) i++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("drain_beats", i, 30);
    chk("done_after_last", done, 1);
    chk("out_valid_after_last", out_valid, 0);
    chk("out_last_after_last", out_last, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    // rst wins over a simultaneous start
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    tick();
    chk("idle_in_ready", in_ready, 0);

    // 1: plain frame 100..123, downstream always ready
    pulse_start();
    chk("collect_in_ready", in_ready, 1);
    collect(100, 1, 1'b0, -1, -1);
    drain(100, 1, 1'b0);
`ifdef SG_COLLECT_CHECKSUM_EN
    chk("checksum_ramp", longint'($signed(checksum)), 3345);
`endif
    tick();
    chk("done_holds", done, 1);

    // 2 + 5: back-to-back start from DONE, random input gaps, toggled out_ready
    pulse_start();
    chk("done_cleared", done, 0);
    collect(100, 1, 1'b1, -1, -1);
    drain(100, 1, 1'b1);

    // 3: start during COLLECT is ignored
    pulse_start();
    collect(100, 1, 1'b0, 6, -1);
    drain(100, 1, 1'b0);

    // 4: reset after beat 10 aborts the frame; next frame is clean
    pulse_start();
    collect(100, 1, 1'b1, -1, 11);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_done", done, 0);
    tick(); tick();
    chk("abort_no_output", out_valid, 0);
    pulse_start();
    collect(-5, 1, 1'b0, -1, -1);
    drain(-5, 1, 1'b1);

`ifdef SG_COLLECT_CHECKSUM_EN
    // 6: all-negative frame
    pulse_start();
    chk("checksum_cleared", longint'($signed(checksum)), 0);
    collect(-1, 0, 1'b0, -1, -1);
    drain(-1, 0, 1'b0);
    chk("checksum_neg", longint'($signed(checksum)), -30);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
